// File: rtl/jk_mode_counter_if.sv
// Bus interface for jk_mode_counter.
// Carries the control/data inputs (en, mode, j, k, d) and the state outputs
// (q, qbar, tc, wrap). Clock and clear stay as plain ports on the block.
//   master : drives en/mode/j/k/d, observes q/qbar/tc/wrap (testbench or datapath)
//   slave  : the counter itself
interface jk_mode_counter_if #(
  parameter int unsigned WIDTH = 4
);
  logic             en;
  logic [1:0]       mode;
  logic [WIDTH-1:0] j;
  logic [WIDTH-1:0] k;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] qbar;
  logic             tc;
  logic             wrap;

  modport master (
    output en, mode, j, k, d,
    input  q, qbar, tc, wrap
  );

  modport slave (
    input  en, mode, j, k, d,
    output q, qbar, tc, wrap
  );
endinterface

// File: rtl/jk_mode_counter.sv
// jk_mode_counter: WIDTH-bit register bank with per-bit J/K control that also
// runs as a modulo-MODULUS up/down counter with parallel load.
//
// Ports
//   clk  : rising-edge clock
//   clr  : asynchronous active-low clear, forces q=RESET_VAL and wrap=0
//   bus  : jk_mode_counter_if.slave
//            en   - synchronous enable, 0 holds q and drops wrap
//            mode - 00 JK, 01 up, 10 down, 11 load
//            j/k  - per-bit JK controls (mode 00)
//            d    - load data (mode 11), clamped to MODULUS-1
//            q    - registered state, qbar = ~q
//            tc   - terminal count (combinational from q and mode)
//            wrap - registered pulse, high the cycle after a wrap
//
// Build option: define JK_MODE_COUNTER_SAT_EN for a saturating counter. Up at
// the top and down at zero then hold q, and wrap flags each blocked step.
module jk_mode_counter #(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned MODULUS   = 16,
  parameter int unsigned RESET_VAL = 0
) (
  input  logic                 clk,
  input  logic                 clr,
  jk_mode_counter_if.slave     bus
);

  // Elaboration-time legality checks.
  if (WIDTH < 1 || WIDTH > 16) begin : g_bad_width
    $error("jk_mode_counter: WIDTH must be 1..16");
  end
  if (MODULUS < 2 || MODULUS > (2 ** WIDTH)) begin : g_bad_modulus
    $error("jk_mode_counter: MODULUS must be 2..2**WIDTH");
  end
  if (RESET_VAL >= MODULUS) begin : g_bad_reset
    $error("jk_mode_counter: RESET_VAL must be < MODULUS");
  end

  localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] RstVal = WIDTH'(RESET_VAL);

  typedef enum logic [1:0] {
    ModeJk   = 2'b00,
    ModeUp   = 2'b01,
    ModeDown = 2'b10,
    ModeLoad = 2'b11
  } mode_e;

  logic [WIDTH-1:0] q_q, q_d;
  logic             wrap_q, wrap_d;
  mode_e            mode;

  assign mode = mode_e'(bus.mode);

  always_comb begin
    q_d    = q_q;
    wrap_d = 1'b0;
    if (bus.en) begin
      case (mode)
        // Per bit: 00 hold, 01 clear, 10 set, 11 toggle.
        ModeJk: q_d = (bus.j & ~q_q) | (~bus.k & q_q);
        ModeUp: begin
          // >= also catches out-of-range values left behind by JK mode.
          if (q_q >= MaxVal) begin
`ifdef JK_MODE_COUNTER_SAT_EN
            q_d = q_q;
`else
            q_d = '0;
`endif
            wrap_d = 1'b1;
          end else begin
            q_d = q_q + 1'b1;
          end
        end
        ModeDown: begin
          if (q_q == '0) begin
`ifdef JK_MODE_COUNTER_SAT_EN
            q_d = q_q;
`else
            q_d = MaxVal;
`endif
            wrap_d = 1'b1;
          end else if (q_q > MaxVal) begin
            // Out-of-range value re-enters the count range without a wrap.
            q_d = MaxVal;
          end else begin
            q_d = q_q - 1'b1;
          end
        end
        ModeLoad: q_d = (bus.d > MaxVal) ? MaxVal : bus.d;
        default:  q_d = q_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      q_q    <= RstVal;
      wrap_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      wrap_q <= wrap_d;
    end
  end

  assign bus.q    = q_q;
  assign bus.qbar = ~q_q;
  assign bus.wrap = wrap_q;
  assign bus.tc   = ((mode == ModeUp) && (q_q == MaxVal)) ||
                    ((mode == ModeDown) && (q_q == '0));

endmodule

// File: tb/tb_jk_mode_counter.sv
// Self-checking bench for jk_mode_counter (WIDTH=4, MODULUS=10, RESET_VAL=0).
// A behavioural model tracks the expected state from the mode rules using
// plain integer arithmetic; a compare process checks every output on each
// falling clock edge, and a directed sequence pins known literal values.
module tb_jk_mode_counter;

  localparam int unsigned W   = 4;
  localparam int unsigned MOD = 10;
  localparam int unsigned RV  = 0;

  logic clk;
  logic clr;
  int   n_chk = 0;
  int   n_err = 0;

  jk_mode_counter_if #(.WIDTH(W)) bif ();

  jk_mode_counter #(
    .WIDTH    (W),
    .MODULUS  (MOD),
    .RESET_VAL(RV)
  ) dut (
    .clk(clk),
    .clr(clr),
    .bus(bif)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural model
  int m_q    = RV;
  int m_wrap = 0;

  always @(posedge clk or negedge clr) begin
    if (!clr) begin
      m_q    = RV;
      m_wrap = 0;
    end else if (!bif.en) begin
      m_wrap = 0;
    end else begin
      m_wrap = 0;
      case (bif.mode)
        2'd0: begin
          int nq;
          nq = 0;
          for (int i = 0; i < int'(W); i++) begin
            int b;
            b = (m_q >> i) & 1;
            case ({bif.j[i], bif.k[i]})
              2'b00: b = b;
              2'b01: b = 0;
              2'b10: b = 1;
              default: b = 1 - b;
            endcase
            nq = nq | (b << i);
          end
          m_q = nq;
        end
        2'd1: begin
          if (m_q >= int'(MOD) - 1) begin
`ifndef JK_MODE_COUNTER_SAT_EN
            m_q = 0;
`endif
            m_wrap = 1;
          end else begin
            m_q = m_q + 1;
          end
        end
        2'd2: begin
          if (m_q == 0) begin
`ifndef JK_MODE_COUNTER_SAT_EN
            m_q = int'(MOD) - 1;
`endif
            m_wrap = 1;
          end else if (m_q > int'(MOD) - 1) begin
            m_q = int'(MOD) - 1;
          end else begin
            m_q = m_q - 1;
          end
        end
        default: m_q = (int'(bif.d) >= int'(MOD)) ? int'(MOD) - 1 : int'(bif.d);
      endcase
    end
  end

  // Per-cycle compare against the model
  always @(negedge clk) begin
    int exp_tc;
    exp_tc = ((bif.mode == 2'd1) && (m_q == int'(MOD) - 1)) ||
             ((bif.mode == 2'd2) && (m_q == 0)) ? 1 : 0;
    n_chk += 4;
    if (int'(bif.q) != m_q) begin
      n_err++;
      $display("FAIL model_q t=%0t: got %0d expected %0d", $time, bif.q, m_q);
    end
    if (int'(bif.qbar) != ((~m_q) & ((1 << W) - 1))) begin
      n_err++;
      $display("FAIL model_qbar t=%0t: got %0h expected %0h", $time, bif.qbar,
               (~m_q) & ((1 << W) - 1));
    end
    if (int'(bif.tc) != exp_tc) begin
      n_err++;
      $display("FAIL model_tc t=%0t: got %0d expected %0d", $time, bif.tc, exp_tc);
    end
    if (int'(bif.wrap) != m_wrap) begin
      n_err++;
      $display("FAIL model_wrap t=%0t: got %0d expected %0d", $time, bif.wrap, m_wrap);
    end
  end

  task automatic chk(input string name, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic set_in(input logic en, input logic [1:0] mode, input logic [W-1:0] j,
                        input logic [W-1:0] k, input logic [W-1:0] d);
    bif.en   = en;
    bif.mode = mode;
    bif.j    = j;
    bif.k    = k;
    bif.d    = d;
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    clr = 1'b0;
    set_in(1'b0, 2'd0, '0, '0, '0);
    #3;
    chk("reset_q", int'(bif.q), 0);
    chk("reset_qbar", int'(bif.qbar), 15);
    chk("reset_wrap", int'(bif.wrap), 0);
    tick();
    clr = 1'b1;

    // Load 8 then count up through the top.
    set_in(1'b1, 2'd3, '0, '0, 4'd8);
    tick();
    chk("load8", int'(bif.q), 8);
    set_in(1'b1, 2'd1, '0, '0, '0);
    tick();
    chk("up_to9", int'(bif.q), 9);
    chk("up_tc", int'(bif.tc), 1);
    chk("up_nowrap", int'(bif.wrap), 0);
    tick();
`ifdef JK_MODE_COUNTER_SAT_EN
    chk("up_sat_q", int'(bif.q), 9);
`else
    chk("up_wrap_q", int'(bif.q), 0);
`endif
    chk("up_wrap", int'(bif.wrap), 1);
    set_in(1'b1, 2'd0, '0, '0, '0);
    tick();
    chk("wrap_drops", int'(bif.wrap), 0);

    // JK mode from 0101.
    set_in(1'b1, 2'd3, '0, '0, 4'd5);
    tick();
    set_in(1'b1, 2'd0, 4'b1100, 4'b1010, '0);
    tick();
    chk("jk_mix", int'(bif.q), 4'b1101);
    chk("jk_tc0", int'(bif.tc), 0);
    set_in(1'b1, 2'd0, 4'hF, 4'hF, '0);
    tick();
    chk("jk_toggle", int'(bif.q), 4'b0010);

    // Down from 0.
    set_in(1'b1, 2'd3, '0, '0, 4'd0);
    tick();
    set_in(1'b1, 2'd2, '0, '0, '0);
    #1;
    chk("down_tc", int'(bif.tc), 1);
    tick();
`ifdef JK_MODE_COUNTER_SAT_EN
    chk("down_sat_q", int'(bif.q), 0);
`else
    chk("down_wrap_q", int'(bif.q), 9);
`endif
    chk("down_wrap", int'(bif.wrap), 1);

    // Out-of-range value via JK, then down clamps without wrap.
    set_in(1'b1, 2'd0, 4'hC, 4'h3, '0);
    tick();
    chk("jk_setC", int'(bif.q), 12);
    set_in(1'b1, 2'd2, '0, '0, '0);
    tick();
    chk("down_clamp_q", int'(bif.q), 9);
    chk("down_clamp_wrap", int'(bif.wrap), 0);

    // Load clamp and enable hold.
    set_in(1'b1, 2'd3, '0, '0, 4'hE);
    tick();
    chk("load_clamp", int'(bif.q), 9);
    set_in(1'b1, 2'd3, '0, '0, 4'd3);
    tick();
    chk("load3", int'(bif.q), 3);
    set_in(1'b0, 2'd1, 4'hF, 4'hF, 4'hE);
    tick();
    chk("en0_hold", int'(bif.q), 3);
    chk("en0_wrap", int'(bif.wrap), 0);

    // Asynchronous clear mid-count.
    set_in(1'b1, 2'd3, '0, '0, 4'd5);
    tick();
    set_in(1'b1, 2'd1, '0, '0, '0);
    tick();
    tick();
    chk("count7", int'(bif.q), 7);
    #2;
    clr = 1'b0;
    #1;
    chk("aclr_q", int'(bif.q), 0);
    chk("aclr_qbar", int'(bif.qbar), 15);
    chk("aclr_wrap", int'(bif.wrap), 0);
    tick();
    clr = 1'b1;

    // Randomized phase, with occasional mid-cycle clear pulses.
    for (int n = 0; n < 3000; n++) begin
      set_in(($urandom_range(0, 7) != 0), 2'($urandom_range(0, 3)),
             W'($urandom), W'($urandom), W'($urandom));
      if ($urandom_range(0, 60) == 0) begin
        #1;
        clr = 1'b0;
        #1;
        clr = 1'b1;
      end
      tick();
    end

    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
